edge_detect_mc: RTL and testbench

Parametrised multi-channel edge detector, successor to the single-bit rising/falling edge checker. Each channel:
- synchronises an asynchronous input;
- rejects glitches shorter than a programmable number of cycles;
- emits single-cycle rising/falling pulses.

A mode-qualified sticky event flag per channel, plus an aggregated interrupt, lets slow control logic poll or clear events. The block sits between external/asynchronous signal pins and the control FSMs.

---
 rtl/edge_detect_mc.sv | 90 +++++++++
 tb/tb_edge_detect_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter,
// registered rise/fall pulses and mode-qualified sticky flags with an OR'd irq.
`timescale 1ns/1ps
module edge_detect_mc #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter bit          INIT_LVL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D_signal,
  input  logic [1:0]       edge_sel,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] flag,
  output logic             irq
);

  localparam int unsigned      CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FILT_LEN - 1);
  localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT_LVL}};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  lvl_q;
  logic [WIDTH-1:0]                  lvl_d;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_d;
  logic [WIDTH-1:0]                  pos_d;
  logic [WIDTH-1:0]                  neg_d;
  logic [WIDTH-1:0]                  flag_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; stage 0 samples the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT_VEC}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], D_signal};
    end
  end

  // Filter next state; an edge is the cycle the accepted level flips.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    pos_d = '0;
    neg_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        lvl_d[i] = s[i];
        cnt_d[i] = '0;
        pos_d[i] = s[i];
        neg_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    // Set has priority over clear.
    flag_d = (flag & ~flag_clr)
           | (pos_d & {WIDTH{edge_sel[0]}})
           | (neg_d & {WIDTH{edge_sel[1]}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q    <= INIT_VEC;
      cnt_q    <= '0;
      pos_edge <= '0;
      neg_edge <= '0;
      flag     <= '0;
    end else begin
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      pos_edge <= pos_d;
      neg_edge <= neg_d;
      flag     <= flag_d;
    end
  end

  assign level = lvl_q;
  assign irq   = |flag;

endmodule

// File: tb/tb_edge_detect_mc.sv
// Directed bench for edge_detect_mc: default instance (FILT_LEN=4) plus a
// FILT_LEN=1 instance sharing clock and reset.
`timescale 1ns/1ps
module tb_edge_detect_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d, flag_clr, pos_edge, neg_edge, level, flag;
  logic [1:0] edge_sel;
  logic       irq;

  logic [7:0] d1, flag_clr1, pos1, neg1, lvl1, flag1;
  logic [1:0] edge_sel1;
  logic       irq1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] seen;

  always #5 clk = ~clk;

  edge_detect_mc dut (
    .clk(clk), .rst_n(rst_n), .D_signal(d), .edge_sel(edge_sel),
    .flag_clr(flag_clr), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .level(level), .flag(flag), .irq(irq)
  );

  edge_detect_mc #(.FILT_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .D_signal(d1), .edge_sel(edge_sel1),
    .flag_clr(flag_clr1), .pos_edge(pos1), .neg_edge(neg1),
    .level(lvl1), .flag(flag1), .irq(irq1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; d = '0; flag_clr = '0; edge_sel = 2'b00;
    d1 = '0; flag_clr1 = '0; edge_sel1 = 2'b01;
    #20;
    check("rst_pos",   pos_edge, 8'h00);
    check("rst_neg",   neg_edge, 8'h00);
    check("rst_level", level,    8'h00);
    check("rst_flag",  flag,     8'h00);
    check("rst_irq",   8'(irq),  8'h00);
    check("rst_lvl1",  lvl1,     8'h00);
    rst_n = 1'b1;
    step(1);

    // Idle: no pulses with static inputs.
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen |= pos_edge | neg_edge;
    end
    check("idle_pulses", seen, 8'h00);

    // Clean rise and fall on ch0, latency E0+5.
    d = 8'h01;
    step(5);
    check("ch0_pre_rise", pos_edge, 8'h00);
    step(1);
    check("ch0_rise",     pos_edge, 8'h01);
    check("ch0_level_hi", level,    8'h01);
    step(1);
    check("ch0_rise_1cy", pos_edge, 8'h00);
    step(3);
    d = 8'h00;
    step(5);
    check("ch0_pre_fall", neg_edge, 8'h00);
    step(1);
    check("ch0_fall",     neg_edge, 8'h01);
    check("ch0_level_lo", level,    8'h00);
    step(1);
    check("ch0_fall_1cy", neg_edge, 8'h00);
    check("ch0_no_flag",  flag,     8'h00);

    // Glitch of 3 cycles on ch1 is rejected.
    d = 8'h02;
    step(3);
    d = 8'h00;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen |= pos_edge | neg_edge | level;
    end
    check("ch1_glitch", seen, 8'h00);

    // 4-cycle pulse on ch1 is accepted, then falls 4 cycles later.
    d = 8'h02;
    step(4);
    d = 8'h00;
    step(1);
    check("ch1_pre_rise", pos_edge, 8'h00);
    step(1);
    check("ch1_rise",     pos_edge, 8'h02);
    check("ch1_level_hi", level,    8'h02);
    step(3);
    check("ch1_pre_fall", neg_edge, 8'h00);
    check("ch1_level_hd", level,    8'h02);
    step(1);
    check("ch1_fall",     neg_edge, 8'h02);
    check("ch1_level_lo", level,    8'h00);
    step(1);
    check("ch1_fall_1cy", neg_edge, 8'h00);

    // Rising-only qualification on ch2.
    edge_sel = 2'b01;
    d = 8'h04;
    step(6);
    check("sel01_pos",  pos_edge, 8'h04);
    check("sel01_flag", flag,     8'h04);
    check("sel01_irq",  8'(irq),  8'h01);
    step(2);
    d = 8'h00;
    step(6);
    check("sel01_neg",       neg_edge, 8'h04);
    check("sel01_flag_hold", flag,     8'h04);
    flag_clr = 8'h04;
    step(1);
    flag_clr = 8'h00;
    check("clr_flag", flag,    8'h00);
    check("clr_irq",  8'(irq), 8'h00);

    // Falling-only qualification.
    edge_sel = 2'b10;
    d = 8'h04;
    step(6);
    check("sel10_pos",      pos_edge, 8'h04);
    check("sel10_flag_pos", flag,     8'h00);
    step(2);
    d = 8'h00;
    step(6);
    check("sel10_neg",      neg_edge, 8'h04);
    check("sel10_flag_neg", flag,     8'h04);
    check("sel10_irq",      8'(irq),  8'h01);
    flag_clr = 8'h04;
    step(1);
    flag_clr = 8'h00;
    check("sel10_clr", flag, 8'h00);

    // No qualification: edges still pulse, flags never set.
    edge_sel = 2'b00;
    d = 8'h04;
    step(6);
    check("sel00_pos",  pos_edge, 8'h04);
    check("sel00_flag", flag,     8'h00);
    step(2);
    d = 8'h00;
    step(6);
    check("sel00_neg",   neg_edge, 8'h04);
    check("sel00_flag2", flag,     8'h00);

    // Clear coincident with a qualifying edge on ch3: set wins.
    edge_sel = 2'b11;
    d = 8'h08;
    step(5);
    flag_clr = 8'h08;
    step(1);
    flag_clr = 8'h00;
    check("setclr_pos",  pos_edge, 8'h08);
    check("setclr_flag", flag,     8'h08);
    d = 8'h00;
    step(8);
    flag_clr = 8'hFF;
    step(1);
    flag_clr = 8'h00;
    check("all_clr", flag, 8'h00);

    // Simultaneous rise on every channel.
    d = 8'hFF;
    step(5);
    check("all_pre",   pos_edge, 8'h00);
    step(1);
    check("all_pos",   pos_edge, 8'hFF);
    check("all_level", level,    8'hFF);
    check("all_flag",  flag,     8'hFF);
    step(1);
    check("all_1cy",   pos_edge, 8'h00);

    // Async reset while the fall is part-way through the filter.
    d = 8'h00;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", level,    8'h00);
    check("arst_flag",  flag,     8'h00);
    check("arst_irq",   8'(irq),  8'h00);
    check("arst_neg",   neg_edge, 8'h00);
    step(1);
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen |= pos_edge | neg_edge | level;
    end
    check("arst_quiet", seen, 8'h00);

    // FILT_LEN=1 instance: rise at E0+2.
    d1 = 8'h01;
    step(2);
    check("f1_pre_rise", pos1, 8'h00);
    step(1);
    check("f1_rise",  pos1,  8'h01);
    check("f1_level", lvl1,  8'h01);
    check("f1_flag",  flag1, 8'h01);
    step(1);
    check("f1_1cy",   pos1,  8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
